// File: rtl/register_file.sv
// 32 x 64-bit register file with two combinational read ports and a committed-write counter.
// Optional write-through bypass on the read ports: define REGFILE_BYPASS_EN.
module register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [63:0] WriteData,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2,
    output logic [63:0] WriteCount
);

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] write_count;
    logic              write_en_c;

    // A write commits only outside reset and never to x0.
    assign write_en_c = RegWrite && (WriteReg != ADDR_W'(0)) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            write_count <= '0;
        end else if (write_en_c) begin
            regs[WriteReg] <= WriteData;
            write_count    <= write_count + DATA_W'(1);
        end
    end

    assign WriteCount = write_count;

    // x0 is forced to zero on read regardless of stored contents.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadRegisterNonZero(ReadReg1)) begin
`ifdef REGFILE_BYPASS_EN
            ReadData1 = (write_en_c && (WriteReg == ReadReg1)) ? WriteData : regs[ReadReg1];
`else
            ReadData1 = regs[ReadReg1];
`endif
        end
        if (ReadRegisterNonZero(ReadReg2)) begin
`ifdef REGFILE_BYPASS_EN
            ReadData2 = (write_en_c && (WriteReg == ReadReg2)) ? WriteData : regs[ReadReg2];
`else
            ReadData2 = regs[ReadReg2];
`endif
        end
    end

    function automatic logic ReadRegisterNonZero(input logic [ADDR_W-1:0] idx);
        return idx != ADDR_W'(0);
    endfunction

endmodule
